label_writer: RTL
=================

LABEL_WRITER -- requirements
Module: label_writer

Interface
REQ-001 Parameter ADDR_W, default 8, label RAM address width (2^ADDR_W cells).
REQ-002 Parameter COLS, default 32, characters per row; power of two, less than 2^ADDR_W.
REQ-003 i_clk  input  1  single clock; all state changes on rising edge.
REQ-004 i_rst  input  1  reset, synchronous and active-high.
REQ-005 i_empty_n  input  1  FIFO not-empty flag; i_data is valid while high.
REQ-006 i_data  input  8  FIFO head byte, first-word-fall-through.
REQ-007 i_clr  input  1  one-cycle clear-screen request.
REQ-008 o_rd  output  1  FIFO pop strobe, one cycle per consumed byte.
REQ-009 o_wr_en  output  1  label RAM write enable.
REQ-010 o_wr_addr  output  ADDR_W  label RAM write address.
REQ-011 o_wr_data  output  8  label RAM write data.
REQ-012 o_cursor  output  ADDR_W  current cursor cell.
REQ-013 o_busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have three states: IDLE, WRITE and CLEAR; o_wr_en, o_wr_addr and o_wr_data SHALL be registered.
REQ-015 IDLE with i_clr=1 SHALL go to CLEAR, with write address 0; o_rd=0 in that cycle. i_clr has priority over the FIFO.
REQ-016 IDLE with i_clr=0 and i_empty_n=1 SHALL assert o_rd combinationally and decode i_data in the same cycle.
- Printable byte 0x20..0x7E: next cycle o_wr_en=1, o_wr_addr=cursor, o_wr_data=byte (state WRITE); cursor+1 mod 2^ADDR_W.
- 0x0A (LF): cursor = next row start (cursor & ~(COLS-1)) + COLS, mod 2^ADDR_W; no write.
- 0x0D (CR): cursor = cursor & ~(COLS-1); no write.
- 0x08 (BS): if cursor != 0, cursor-1, then write 0x20 at the new cursor (WRITE). If cursor = 0, do nothing.
- 0x0C (FF): enter CLEAR; same as i_clr.
- All other bytes: consumed (o_rd=1) and otherwise ignored.
REQ-017 WRITE SHALL last exactly one cycle, then return to IDLE; o_rd=0 in WRITE. Sustained throughput is one printable byte per 2 cycles.
REQ-018 CLEAR SHALL assert o_wr_en on each of 2^ADDR_W consecutive cycles, with o_wr_data=0x20 and o_wr_addr stepping 0,1,...,2^ADDR_W-1.
- After the last write: cursor=0, state IDLE.
- o_rd=0 throughout CLEAR; i_clr during CLEAR is ignored and does not restart it.
REQ-019 Cursor wrap: a printable byte at cursor 2^ADDR_W-1 SHALL write there, and the cursor becomes 0. LF on the last row SHALL wrap to cell 0. There is no scrolling.
REQ-020 o_rd SHALL never be asserted while i_empty_n=0.
REQ-021 o_wr_en SHALL be 0 in IDLE.
REQ-022 Cursor arithmetic SHALL be ADDR_W-bit unsigned modulo 2^ADDR_W.

Reset
REQ-023 i_rst=1 SHALL force, on the next edge: state IDLE, cursor 0, o_wr_en 0, o_wr_addr 0, o_wr_data 0, o_rd 0, o_busy 0.
REQ-024 Reset SHALL take priority over every other input, including mid-CLEAR and mid-WRITE. An aborted CLEAR is not resumed.
REQ-025 While i_rst=1, o_rd SHALL be held 0 combinationally, so no byte is lost.

Verification
REQ-026 Printable bytes: from reset, FIFO holds 'H','I' (0x48,0x49) -> writes (0x00,0x48) and (0x01,0x49) on alternate cycles, o_rd twice, cursor=2.
REQ-027 LF/CR/BS: cursor=5, feed 0x0A -> cursor=32, no write. Then 0x41 -> write (32,0x41), cursor=33. Then 0x08 -> write (32,0x20), cursor=32. Then 0x0D -> cursor=32.
REQ-028 Wrap: cursor=255, feed 0x5A -> write (255,0x5A), cursor=0. Cursor=230, feed 0x0A -> cursor=0.
REQ-029 Clear and priority: pulse i_clr with FIFO non-empty in the same cycle -> o_rd=0, then 256 consecutive writes of 0x20 at 0..255, then FIFO drained from cursor 0. i_clr pulsed mid-clear has no effect.
REQ-030 Reset mid-CLEAR: assert i_rst at write address 100 -> o_wr_en=0, cursor=0, o_busy=0 next cycle. With FIFO non-empty and i_rst=1, o_rd stays 0.
REQ-031 Ignored byte and underflow: feed 0x07 -> o_rd pulse, no write, cursor unchanged. Hold i_empty_n=0 for 100 cycles -> o_rd never asserted.

Source files
------------

// File: rtl/label_writer.sv
// Character-cell label writer: decodes FIFO bytes into label RAM writes and a cursor, plus a full-screen clear.
// Writes appear one cycle after the byte is popped; bytes are popped only in IDLE, so WRITE/CLEAR stall the FIFO.
module label_writer #(
  parameter int ADDR_W = 8,
  parameter int COLS   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_empty_n,
  input  logic [7:0]        i_data,
  input  logic              i_clr,
  output logic              o_rd,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic [ADDR_W-1:0] o_cursor,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] COL_MASK  = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_CELL = '1;
  localparam logic [7:0]        SPACE     = 8'h20;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cursor, cursor_nxt;
  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [7:0]        wr_data_nxt;

  // Pop only when idle with no pending clear; reset gates it so no byte is lost.
  always_comb o_rd = !i_rst && (state == IDLE) && !i_clr && i_empty_n;

  always_comb begin
    state_nxt   = state;
    cursor_nxt  = cursor;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = o_wr_addr;
    wr_data_nxt = o_wr_data;
    unique case (state)
      IDLE: begin
        if (i_clr) begin
          state_nxt   = CLEAR;
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = '0;
          wr_data_nxt = SPACE;
        end else if (o_rd) begin
          if (i_data >= 8'h20 && i_data <= 8'h7E) begin
            state_nxt   = WRITE;
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = cursor;
            wr_data_nxt = i_data;
            cursor_nxt  = cursor + ONE;
          end else begin
            case (i_data)
              8'h0A: cursor_nxt = (cursor & ~COL_MASK) + ROW_STEP;
              8'h0D: cursor_nxt = cursor & ~COL_MASK;
              8'h08: begin
                if (cursor != '0) begin
                  state_nxt   = WRITE;
                  wr_en_nxt   = 1'b1;
                  wr_addr_nxt = cursor - ONE;
                  wr_data_nxt = SPACE;
                  cursor_nxt  = cursor - ONE;
                end
              end
              8'h0C: begin
                state_nxt   = CLEAR;
                wr_en_nxt   = 1'b1;
                wr_addr_nxt = '0;
                wr_data_nxt = SPACE;
              end
              default: ;
            endcase
          end
        end
      end
      WRITE: state_nxt = IDLE;
      CLEAR: begin
        // The address register doubles as the clear sweep counter.
        if (o_wr_addr == LAST_CELL) begin
          state_nxt  = IDLE;
          cursor_nxt = '0;
        end else begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = o_wr_addr + ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      cursor    <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
    end else begin
      state     <= state_nxt;
      cursor    <= cursor_nxt;
      o_wr_en   <= wr_en_nxt;
      o_wr_addr <= wr_addr_nxt;
      o_wr_data <= wr_data_nxt;
    end
  end

  assign o_cursor = cursor;
  assign o_busy   = (state != IDLE);

endmodule
